mor1kx_rf_mport_marocchino: RTL
===============================

// Module: mor1kx_rf_mport_marocchino
// PURPOSE
//  Multi-port, multi-context GPR file for the MAROCCHINO pipeline.
//  Supports NUM_RD read ports addressed from FETCH and NUM_WB write-back ports.
//  Bypasses WB results into FETCH->DECODE, with write-first semantics on every path.
//  Holds NUM_CTX shadow banks, selected by ctx_i; all banks are reachable over the SPR bus (GPR group).
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32  data width W
//  OPTION_RF_ADDR_WIDTH  5   per-bank GPR index width A
//  NUM_RD                2   read ports (FETCH address -> DECODE operand)
//  NUM_WB                2   write-back ports
//  NUM_CTX               1   register banks (power of 2, 1..16)
//  ZERO_R0               1   1: writes to r0 are dropped and reads of r0 return 0
//  CLEAR_ON_RESET        0   1: all storage is zeroed by rst
// PORTS
//  clk             in   1         clock
//  rst             in   1         reset rst, synchronous, active-high
//  padv_decode_i   in   1         decode advance (informational only)
//  wb_new_result_i in   1         1-clk strobe: WB bus carries new results
//  pipeline_flush_i in  1         flush: blocks writes, clears bypass state
//  ctx_i           in   log2(CTX) active bank for pipeline reads/writes
//  fetch_rf_adr_valid_i in 1      FETCH addresses valid (latch new operands)
//  fetch_rf_adr_i  in   RD*A      packed FETCH read addresses, port i at [i*A+:A]
//  dcod_rf_req_i   in   RD        DECODE port i really uses its operand
//  dcod_rf_adr_i   in   RD*A      DECODE-stage addresses, same packing as FETCH
//  dcod_imm_sel_i  in   RD        port i output replaced by dcod_immediate_i
//  dcod_immediate_i in  W         immediate operand
//  wb_rf_wb_i      in   WB        write request per WB port
//  wb_rfd_adr_i    in   WB*A      WB destination addresses
//  wb_result_i     in   WB*W      WB data
//  spr_bus_addr_i  in   16        SPR address
//  spr_bus_stb_i   in   1         SPR strobe
//  spr_bus_we_i    in   1         SPR write
//  spr_bus_dat_i   in   W         SPR write data
//  spr_gpr_ack_o   out  1         SPR access complete
//  spr_gpr_dat_o   out  W         SPR read data
//  dcod_rf_o       out  RD*W      DECODE operands
// BEHAVIOUR
//  - Effective write: we[k] = wb_rf_wb_i[k] & wb_new_result_i & ~pipeline_flush_i & ~(ZERO_R0 & adr==0).
//  - Multiple WB ports writing the same address in one cycle: the highest index k wins (storage and bypass).
//  - Read latency 1: fetch address applied with valid in cycle N -> operand on dcod_rf_o from N+1,
//    held until the next fetch_rf_adr_valid_i.
//  - Write-first: a WB write to a FETCH-address match in cycle N makes the N+1 operand the new data.
//  - DECODE hold: no fetch valid, effective we[k], dcod address match -> per-port bypass register
//    captures that data; it stays selected until the next fetch valid or a flush.
//  - Combinational forward: current-cycle effective-WB address match on dcod_rf_adr_i with dcod_rf_req_i
//    set -> output that wb_result_i immediately.
//  - Output priority per port: imm_sel > live WB match > bypass register > storage.
//  - r0 read with ZERO_R0 = 1: output 0 regardless of bypass.
//  - Flush: clears all bypass flags the same cycle; storage is unaffected.
//  - SPR GPR group: spr_bus_addr_i[15:9] == 7'h2; bank = addr[A+:log2(CTX)]; index = addr[A-1:0].
//    Out-of-range bank: write ignored, read returns 0; ack still given.
//  - SPR write: ack in the same cycle if no effective WB write that cycle; otherwise ack is withheld
//    (WB wins) and the write retries the next cycle.
//  - SPR read: registered; data and ack both one cycle after the strobe; ack deasserts with stb.
//  - SPR write to a bank/index currently held in DECODE does not update operands; CTRL stalls around SPR.
//  - Reset: bypass flags 0, spr_gpr_ack_o 0, spr_gpr_dat_o 0; DECODE operand registers 0;
//    storage cleared only if CLEAR_ON_RESET.
//  - ctx_i change takes effect on the next FETCH latch; an operand already in DECODE keeps its bank.
//  - Storage: flop array of NUM_CTX*2^A words x W. Required for NUM_WB > 1; no RAM macros.
// STRUCTURE
//  - mor1kx-defines.v: SPR GPR group code (7'h2), shared with the CTRL SPR decoder.
//  - Sub-module mor1kx_rf_bypass_slot_marocchino, one per read port:
//    hazard compare over NUM_WB ports, highest-index select, bypass data/flag registers, output mux.
//  - Top level: storage array, write arbitration, SPR FSM (IDLE, RD_WAIT), generate loops.
// TESTING
//  - Reset: rst for 1 clk -> ack=0, dcod_rf_o=0; with CLEAR_ON_RESET=1, read r5 -> 0.
//  - WB0 writes r3=0xA5A5_0001 while fetch reads r3 -> dcod_rf_o[0] = 0xA5A5_0001 at N+1.
//  - DECODE holds r4 for 3 clks; WB1 writes r4=0x1234 in clk 2 -> output 0x1234 from clk 2,
//    still 0x1234 after the WB strobe ends.
//  - WB0 and WB1 write r7 = 0x11 / 0x22 in the same cycle -> storage and operand = 0x22;
//    writing r0 = 0xFF -> reads 0.
//  - NUM_CTX=4: SPR write addr 0x400+32*2+6 = 0xBEEF, then ctx_i=2 fetch r6 -> 0xBEEF;
//    ctx 0 r6 unchanged.
//  - SPR write colliding with WB -> no ack that clk, ack the next clk; data stored.
//  - Flush while bypass set -> the next operand comes from storage.

Source files
------------

// File: rtl/mor1kx_rf_mport_marocchino_pkg.sv
// Shared definitions for the MAROCCHINO multi-port register file.
//  - SPR_GROUP_GPR : SPR group code of the GPR window. The CTRL SPR decoder
//                    uses the same code.
//  - spr_state_e   : states of the SPR access FSM.
//  - ctx_width()   : width of a bank-select field. It is never less than
//                    1 bit, so ports stay legal when NUM_CTX == 1.
package mor1kx_rf_mport_marocchino_pkg;

    localparam logic [6:0] SPR_GROUP_GPR = 7'h2;

    typedef enum logic {
        SPR_IDLE,
        SPR_RD_WAIT
    } spr_state_e;

    function automatic int ctx_width(input int num_ctx);
        return (num_ctx > 1) ? $clog2(num_ctx) : 1;
    endfunction

endpackage

// File: rtl/mor1kx_rf_mport_marocchino_if.sv
// SPR bus as seen by the GPR file.
//  master (CTRL) : drives spr_bus_addr/stb/we/dat, receives spr_gpr_ack/dat
//  slave  (GPR)  : receives the bus, returns spr_gpr_ack and spr_gpr_dat
interface mor1kx_rf_mport_marocchino_if #(
    parameter int W = 32
) ();
    logic [15:0]  spr_bus_addr;
    logic         spr_bus_stb;
    logic         spr_bus_we;
    logic [W-1:0] spr_bus_dat;
    logic         spr_gpr_ack;
    logic [W-1:0] spr_gpr_dat;

    modport master (
        output spr_bus_addr, spr_bus_stb, spr_bus_we, spr_bus_dat,
        input  spr_gpr_ack, spr_gpr_dat
    );

    modport slave (
        input  spr_bus_addr, spr_bus_stb, spr_bus_we, spr_bus_dat,
        output spr_gpr_ack, spr_gpr_dat
    );
endinterface

// File: rtl/mor1kx_rf_bypass_slot_marocchino.sv
// One read port of the MAROCCHINO register file. The slot holds the DECODE
// operand register, the write-back hazard compare and the output mux.
//  fetch_valid/fetch_adr : FETCH address. The operand is latched at the clock
//                          edge, write-first against the current WB writes.
//  dcod_adr/dcod_req     : address of the operand now in DECODE, and whether
//                          DECODE uses it.
//  imm_sel/immediate     : replace the operand with the immediate.
//  wb_we/wb_adr/wb_result: effective WB writes, all ports packed together.
//  bank_match            : WB bank equals the bank of the DECODE operand.
//  mem_rdata             : storage word at the FETCH address.
//  operand               : DECODE operand output.
module mor1kx_rf_bypass_slot_marocchino
    import mor1kx_rf_mport_marocchino_pkg::*;
#(
    parameter int W       = 32,
    parameter int A       = 5,
    parameter int NUM_WB  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic                flush,
    input  logic [A-1:0]        fetch_adr,
    input  logic [A-1:0]        dcod_adr,
    input  logic                dcod_req,
    input  logic                imm_sel,
    input  logic [W-1:0]        immediate,
    input  logic [NUM_WB-1:0]   wb_we,
    input  logic [NUM_WB*A-1:0] wb_adr,
    input  logic [NUM_WB*W-1:0] wb_result,
    input  logic                bank_match,
    input  logic [W-1:0]        mem_rdata,
    output logic [W-1:0]        operand
);

    logic         fetch_hit;
    logic [W-1:0] fetch_hit_dat;
    logic         dcod_hit;
    logic [W-1:0] dcod_hit_dat;
    logic [W-1:0] op_q;
    logic         byp_flag;
    logic [W-1:0] byp_dat;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        fetch_hit     = 1'b0;
        fetch_hit_dat = '0;
        dcod_hit      = 1'b0;
        dcod_hit_dat  = '0;
        // Ascending scan: later ports overwrite, so the highest index wins.
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_we[k] && (wb_adr[k*A +: A] == fetch_adr)) begin
                fetch_hit     = 1'b1;
                fetch_hit_dat = wb_result[k*W +: W];
            end
            if (wb_we[k] && bank_match && (wb_adr[k*A +: A] == dcod_adr)) begin
                dcod_hit     = 1'b1;
                dcod_hit_dat = wb_result[k*W +: W];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only. All flops then
    // update together at the edge and the simulation order cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            byp_flag <= 1'b0;
            byp_dat  <= '0;
        end else begin
            if (fetch_valid) begin
                op_q <= fetch_hit ? fetch_hit_dat : mem_rdata;
            end
            // The bypass covers only the operand that stays in DECODE. A new
            // fetch or a flush makes it stale.
            if (fetch_valid || flush) begin
                byp_flag <= 1'b0;
            end else if (dcod_hit) begin
                byp_flag <= 1'b1;
                byp_dat  <= dcod_hit_dat;
            end
        end
    end

    always_comb begin
        operand = op_q;
        if (imm_sel) begin
            operand = immediate;
        end else if ((ZERO_R0 != 0) && (dcod_adr == '0)) begin
            operand = '0;
        end else if (dcod_req && dcod_hit) begin
            operand = dcod_hit_dat;
        end else if (byp_flag) begin
            operand = byp_dat;
        end
    end

endmodule

// File: rtl/mor1kx_rf_mport_marocchino.sv
// Multi-port, multi-context GPR file for the MAROCCHINO pipeline.
//  clk, rst (synchronous, active-high)
//  padv_decode_i        : decode advance; informational, not used
//  wb_new_result_i      : WB bus carries new results this cycle
//  pipeline_flush_i     : blocks writes, clears bypass state
//  ctx_i                : active bank for pipeline reads and writes
//  fetch_rf_adr_valid_i : latch new operands from fetch_rf_adr_i
//  fetch_rf_adr_i       : packed FETCH addresses, port i at [i*A +: A]
//  dcod_rf_req_i, dcod_rf_adr_i, dcod_imm_sel_i, dcod_immediate_i : DECODE side
//  wb_rf_wb_i, wb_rfd_adr_i, wb_result_i : write-back ports
//  spr                  : SPR bus, GPR group access to every bank
//  dcod_rf_o            : packed DECODE operands
module mor1kx_rf_mport_marocchino
    import mor1kx_rf_mport_marocchino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_RD               = 2,
    parameter int NUM_WB               = 2,
    parameter int NUM_CTX              = 1,
    parameter int ZERO_R0              = 1,
    parameter int CLEAR_ON_RESET       = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     padv_decode_i,
    input  logic                                     wb_new_result_i,
    input  logic                                     pipeline_flush_i,
    input  logic [ctx_width(NUM_CTX)-1:0]            ctx_i,
    input  logic                                     fetch_rf_adr_valid_i,
    input  logic [NUM_RD*OPTION_RF_ADDR_WIDTH-1:0]   fetch_rf_adr_i,
    input  logic [NUM_RD-1:0]                        dcod_rf_req_i,
    input  logic [NUM_RD*OPTION_RF_ADDR_WIDTH-1:0]   dcod_rf_adr_i,
    input  logic [NUM_RD-1:0]                        dcod_imm_sel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]          dcod_immediate_i,
    input  logic [NUM_WB-1:0]                        wb_rf_wb_i,
    input  logic [NUM_WB*OPTION_RF_ADDR_WIDTH-1:0]   wb_rfd_adr_i,
    input  logic [NUM_WB*OPTION_OPERAND_WIDTH-1:0]   wb_result_i,
    mor1kx_rf_mport_marocchino_if.slave              spr,
    output logic [NUM_RD*OPTION_OPERAND_WIDTH-1:0]   dcod_rf_o
);

    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int A     = OPTION_RF_ADDR_WIDTH;
    localparam int CTX_W = ctx_width(NUM_CTX);
    localparam int IDX_W = A + $clog2(NUM_CTX);
    localparam int DEPTH = 1 << IDX_W;

    logic [W-1:0]      mem [DEPTH];
    logic [NUM_WB-1:0] wb_we;
    logic              any_wb_we;
    logic [CTX_W-1:0]  dcod_ctx_q;
    logic              bank_match;

    // padv_decode_i and the upper SPR address bits are not used.
    logic unused_bits;
    assign unused_bits = ^{padv_decode_i, spr.spr_bus_addr};

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            wb_we[k] = wb_rf_wb_i[k] & wb_new_result_i & ~pipeline_flush_i &
                       ~((ZERO_R0 != 0) && (wb_rfd_adr_i[k*A +: A] == '0));
        end
    end
    assign any_wb_we = |wb_we;

    // ---------------- SPR address decode ----------------
    logic             spr_cs;
    logic [CTX_W-1:0] spr_bank;
    logic [A-1:0]     spr_index;
    logic             spr_bank_ok;
    logic             spr_zero;
    logic [IDX_W-1:0] spr_idx;
    logic [W-1:0]     spr_rdata;
    logic             spr_wr_go;

    assign spr_cs      = spr.spr_bus_stb && (spr.spr_bus_addr[15:9] == SPR_GROUP_GPR);
    assign spr_bank    = spr.spr_bus_addr[A +: CTX_W];
    assign spr_index   = spr.spr_bus_addr[A-1:0];
    assign spr_bank_ok = int'(spr_bank) < NUM_CTX;
    assign spr_zero    = (ZERO_R0 != 0) && (spr_index == '0);
    // With a single bank the truncation drops the (unused) bank bit.
    assign spr_idx     = IDX_W'({spr_bank, spr_index});
    assign spr_rdata   = (spr_bank_ok && !spr_zero) ? mem[spr_idx] : '0;

    // ---------------- SPR FSM ----------------
    spr_state_e   state_q, state_d;
    logic         ack;
    logic         rd_capture;
    logic [W-1:0] spr_dat_q;

    always_comb begin
        state_d    = state_q;
        ack        = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            SPR_IDLE: begin
                if (spr_cs) begin
                    if (spr.spr_bus_we) begin
                        // WB owns the write path; the SPR write retries next cycle.
                        ack = ~any_wb_we;
                    end else begin
                        rd_capture = 1'b1;
                        state_d    = SPR_RD_WAIT;
                    end
                end
            end
            SPR_RD_WAIT: begin
                ack     = spr.spr_bus_stb;
                state_d = SPR_IDLE;
            end
            default: state_d = SPR_IDLE;
        endcase
    end

    assign spr_wr_go       = (state_q == SPR_IDLE) && spr_cs && spr.spr_bus_we &&
                             !any_wb_we && !rst;
    assign spr.spr_gpr_ack = ack & ~rst;
    assign spr.spr_gpr_dat = spr_dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SPR_IDLE;
            spr_dat_q  <= '0;
            dcod_ctx_q <= '0;
        end else begin
            state_q <= state_d;
            if (rd_capture) begin
                spr_dat_q <= spr_rdata;
            end
            if (fetch_rf_adr_valid_i) begin
                dcod_ctx_q <= ctx_i;
            end
        end
    end

    // An operand already in DECODE keeps its bank. WB writes into another bank must not bypass into it.
    assign bank_match = (ctx_i == dcod_ctx_q);

    // ---------------- storage ----------------
    // NOTE: the array is cleared only when CLEAR_ON_RESET asks for it. Without
    // a reset term it maps to plain enable flops, and software initialises the GPRs.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem[j] <= '0;
                end
            end
        end else begin
            if (spr_wr_go && spr_bank_ok && !spr_zero) begin
                mem[spr_idx] <= spr.spr_bus_dat;
            end
            // The last assignment in the loop wins: the highest WB port writes.
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_we[k]) begin
                    mem[IDX_W'({ctx_i, wb_rfd_adr_i[k*A +: A]})] <= wb_result_i[k*W +: W];
                end
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [IDX_W-1:0] fetch_idx;
        assign fetch_idx = IDX_W'({ctx_i, fetch_rf_adr_i[i*A +: A]});

        mor1kx_rf_bypass_slot_marocchino #(
            .W       (W),
            .A       (A),
            .NUM_WB  (NUM_WB),
            .ZERO_R0 (ZERO_R0)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .fetch_valid (fetch_rf_adr_valid_i),
            .flush       (pipeline_flush_i),
            .fetch_adr   (fetch_rf_adr_i[i*A +: A]),
            .dcod_adr    (dcod_rf_adr_i[i*A +: A]),
            .dcod_req    (dcod_rf_req_i[i]),
            .imm_sel     (dcod_imm_sel_i[i]),
            .immediate   (dcod_immediate_i),
            .wb_we       (wb_we),
            .wb_adr      (wb_rfd_adr_i),
            .wb_result   (wb_result_i),
            .bank_match  (bank_match),
            .mem_rdata   (mem[fetch_idx]),
            .operand     (dcod_rf_o[i*W +: W])
        );
    end

endmodule
